// File: rtl/enc_pkg.sv
// Shared constants and helpers for the request encoder family.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package enc_pkg;

    localparam int N_REQ_DEF  = 4;
    localparam int CODE_W_DEF = 2;

    // Code width that never collapses to zero for tiny request counts.
    function automatic int code_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // One-hot vector with bit idx set; callers size-cast to their width.
    function automatic logic [31:0] onehot(input int idx);
        return 32'd1 << idx;
    endfunction

endpackage

// File: rtl/req_encoder_4x2_prio.sv
// Rotating priority encoder: finds the first set bit of vec at or after start.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   vec   in  N_REQ   candidate request bits
//   start in  CODE_W  index searched first; search wraps N_REQ-1 -> 0
//   idx   out CODE_W  index of the winning bit (0 when none set)
//   any   out 1       at least one bit of vec is set
module prio_enc_4x2
    import enc_pkg::*;
#(
    parameter int N_REQ  = N_REQ_DEF,
    parameter int CODE_W = code_width(N_REQ)
) (
    input  logic [N_REQ-1:0]  vec,
    input  logic [CODE_W-1:0] start,
    output logic [CODE_W-1:0] idx,
    output logic              any
);

    logic [CODE_W-1:0] pos;

    // Walk from the farthest offset back to start so the nearest set bit
    // is the last one written. N_REQ is a power of two, so the CODE_W-bit
    // addition wraps the search modulo N_REQ for free.
    always_comb begin
        idx = '0;
        any = 1'b0;
        pos = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            pos = start + CODE_W'(i);
            if (vec[pos]) begin
                idx = pos;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/req_encoder_4x2.sv
// Registered N-to-log2(N) request encoder with sticky pending bits.
// Latency: req_i before edge t -> pend at t -> code_o/valid_o at t+1; 1 code/cycle.
// Backpressure: valid_o=1 & ready_i=0 holds code_o/valid_o; requests keep accumulating.
//
// Build option: define RR_ARB_EN for round-robin selection (default: fixed
// priority, bit 0 highest, and no rotation pointer is built).
//
// Ports:
//   clk     in  1       rising-edge clock
//   rst     in  1       asynchronous active-high reset
//   req_i   in  N_REQ   request pulses/levels, sampled every edge
//   code_o  out CODE_W  encoded index of the served request
//   valid_o out 1       code_o holds a valid code
//   ready_i in  1       consumer takes code_o this cycle
//   pend_o  out N_REQ   pending-request register
//   busy_o  out 1       anything pending or presented
module req_encoder_4x2
    import enc_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    localparam int CODE_W = code_width(N_REQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_REQ-1:0]  req_i,
    output logic [CODE_W-1:0] code_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [N_REQ-1:0]  pend_o,
    output logic              busy_o
);

    logic [N_REQ-1:0]  pend;
    logic [N_REQ-1:0]  pend_next;
    logic [N_REQ-1:0]  load_mask;
    logic [CODE_W-1:0] start;
    logic [CODE_W-1:0] sel_idx;
    logic              sel_any;
    logic              load_en;

    // Output register is free when empty or being drained this cycle.
    assign load_en = !valid_o || ready_i;

    prio_enc_4x2 #(
        .N_REQ  (N_REQ),
        .CODE_W (CODE_W)
    ) u_prio (
        .vec   (pend),
        .start (start),
        .idx   (sel_idx),
        .any   (sel_any)
    );

`ifdef RR_ARB_EN
    logic [CODE_W-1:0] rr_ptr;

    // Next search begins just past the last winner; CODE_W-bit add wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (load_en && sel_any) begin
            rr_ptr <= sel_idx + CODE_W'(1);
        end
    end

    assign start = rr_ptr;
`else
    assign start = '0;
`endif

    // The served bit is cleared, but a request arriving on the same edge
    // re-arms it so it is never lost.
    always_comb begin
        load_mask = '0;
        if (load_en && sel_any) begin
            load_mask = N_REQ'(onehot(int'(sel_idx)));
        end
        pend_next = (pend & ~load_mask) | req_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend    <= '0;
            code_o  <= '0;
            valid_o <= 1'b0;
        end else begin
            pend <= pend_next;
            if (load_en) begin
                // When nothing is pending code_o keeps its last value.
                if (sel_any) begin
                    code_o <= sel_idx;
                end
                valid_o <= sel_any;
            end
        end
    end

    assign pend_o = pend;
    assign busy_o = (|pend) || valid_o;

endmodule
